// File: rtl/serializer_tx_scheduler.sv
// Transmit-side word scheduler for an 8b/10b serializer: comma training burst,
// data/control round-robin arbitration per word slot, idle and periodic forced commas.
module serializer_tx_scheduler #(
    parameter int                  DATA_WIDTH   = 8,
    parameter int                  SLOT_CYCLES  = 1,
    parameter int                  TRAIN_LEN    = 16,
    parameter int                  COMMA_PERIOD = 256,
    parameter logic [DATA_WIDTH-1:0] COMMA_CODE = 8'hBC
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Link_En,
    input  logic                  i_Data_Valid,
    input  logic [DATA_WIDTH-1:0] i_Data,
    output logic                  o_Data_Ready,
    input  logic                  i_Ctrl_Valid,
    input  logic [DATA_WIDTH-1:0] i_Ctrl,
    input  logic                  i_Ctrl_K,
    output logic                  o_Ctrl_Ready,
    output logic                  o_S_en,
    output logic [DATA_WIDTH-1:0] o_Tx_Data,
    output logic                  o_Tx_K,
    output logic                  o_Word_Strobe,
    output logic [1:0]            o_State,
    output logic                  o_Trained,
    output logic [15:0]           o_Data_Count
);

    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int TW = $clog2(TRAIN_LEN + 1);
    localparam int CW = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_TRAIN = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [SW-1:0]         slot_cnt, slot_nxt;
    logic [TW-1:0]         train_cnt, train_nxt;
    logic [CW-1:0]         comma_cnt, comma_nxt;
    logic                  data_last, data_last_nxt;
    logic                  s_en_nxt, tx_k_nxt, strobe_nxt;
    logic [DATA_WIDTH-1:0] tx_data_nxt;
    logic [15:0]           count_nxt;
    logic                  boundary, forced, arb_slot, grant_data, grant_ctrl;

    // Arbitration is only open on a RUN boundary that is neither forced nor a link drop,
    // so a ready always coincides with a loaded grant.
    always_comb begin
        boundary   = (state != S_OFF) && (slot_cnt == '0);
        forced     = (COMMA_PERIOD != 0) && (comma_cnt == CW'(COMMA_PERIOD - 1));
        arb_slot   = boundary && (state == S_RUN) && i_Link_En && !forced;
        grant_ctrl = arb_slot && i_Ctrl_Valid && (!i_Data_Valid || data_last);
        grant_data = arb_slot && i_Data_Valid && (!i_Ctrl_Valid || !data_last);
    end

    assign o_Data_Ready = grant_data;
    assign o_Ctrl_Ready = grant_ctrl;
    assign o_State      = state;
    assign o_Trained    = (state == S_RUN);

    always_comb begin
        state_nxt     = state;
        slot_nxt      = slot_cnt;
        train_nxt     = train_cnt;
        comma_nxt     = comma_cnt;
        data_last_nxt = data_last;
        s_en_nxt      = o_S_en;
        tx_data_nxt   = o_Tx_Data;
        tx_k_nxt      = o_Tx_K;
        strobe_nxt    = 1'b0;
        count_nxt     = o_Data_Count;

        case (state)
            S_OFF: begin
                if (i_Link_En) begin
                    state_nxt = S_TRAIN;
                    slot_nxt  = '0;
                    s_en_nxt  = 1'b1;
                end
            end
            default: begin
                slot_nxt = (slot_cnt == SW'(SLOT_CYCLES - 1)) ? '0 : slot_cnt + 1'b1;
                if (boundary) begin
                    if (!i_Link_En) begin
                        state_nxt   = S_OFF;
                        slot_nxt    = '0;
                        train_nxt   = '0;
                        comma_nxt   = '0;
                        s_en_nxt    = 1'b0;
                        tx_data_nxt = '0;
                        tx_k_nxt    = 1'b0;
                    end else if (state == S_TRAIN) begin
                        tx_data_nxt = COMMA_CODE;
                        tx_k_nxt    = 1'b1;
                        strobe_nxt  = 1'b1;
                        train_nxt   = train_cnt + 1'b1;
                        if (train_cnt == TW'(TRAIN_LEN - 1)) state_nxt = S_RUN;
                    end else begin
                        strobe_nxt = 1'b1;
                        comma_nxt  = forced ? '0 : comma_cnt + 1'b1;
                        if (grant_ctrl) begin
                            tx_data_nxt   = i_Ctrl;
                            tx_k_nxt      = i_Ctrl_K;
                            data_last_nxt = 1'b0;
                        end else if (grant_data) begin
                            tx_data_nxt   = i_Data;
                            tx_k_nxt      = 1'b0;
                            data_last_nxt = 1'b1;
                            count_nxt     = o_Data_Count + 16'd1;
                        end else begin
                            tx_data_nxt = COMMA_CODE;
                            tx_k_nxt    = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state         <= S_OFF;
            slot_cnt      <= '0;
            train_cnt     <= '0;
            comma_cnt     <= '0;
            data_last     <= 1'b1;
            o_S_en        <= 1'b0;
            o_Tx_Data     <= '0;
            o_Tx_K        <= 1'b0;
            o_Word_Strobe <= 1'b0;
            o_Data_Count  <= '0;
        end else begin
            state         <= state_nxt;
            slot_cnt      <= slot_nxt;
            train_cnt     <= train_nxt;
            comma_cnt     <= comma_nxt;
            data_last     <= data_last_nxt;
            o_S_en        <= s_en_nxt;
            o_Tx_Data     <= tx_data_nxt;
            o_Tx_K        <= tx_k_nxt;
            o_Word_Strobe <= strobe_nxt;
            o_Data_Count  <= count_nxt;
        end
    end

endmodule

// File: tb/tb_serializer_tx_scheduler.sv
// Randomised bench for serializer_tx_scheduler: two configurations run side by side
// against a slot-level behavioural model, plus directed bring-up, arbitration and reset checks.
module tb_serializer_tx_scheduler;

    localparam int S_A = 1, L_A = 4, P_A = 4;
    localparam int S_B = 3, L_B = 4, P_B = 6;

    typedef struct {
        int         mode;       // 0 off, 1 training, 2 running
        int         phase;      // cycles into current slot
        int         sent;       // training commas sent
        int         run_slots;  // RUN slots since last forced comma
        bit         dlast;
        bit         s_en;
        logic [7:0] data;
        bit         k;
        bit         strobe;
        int         count;
    } mdl_t;

    logic       clk = 0, rst = 1, link = 0;
    logic       dv[2], cv[2], ck[2];
    logic [7:0] dd[2], cd[2];
    logic       rdy_d[2], rdy_c[2], s_en[2], txk[2], stb[2], trn[2];
    logic [7:0] txd[2];
    logic [1:0] st[2];
    logic [15:0] cnt[2];

    mdl_t mdl[2];
    bit   acc_d[2], acc_c[2];
    int   checks = 0, errors = 0;
    int   pd = 0, pc = 0;
    bit   fixed = 0;

    always #5 clk = ~clk;

    serializer_tx_scheduler #(.DATA_WIDTH(8), .SLOT_CYCLES(S_A), .TRAIN_LEN(L_A),
                              .COMMA_PERIOD(P_A), .COMMA_CODE(8'hBC)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Link_En(link),
        .i_Data_Valid(dv[0]), .i_Data(dd[0]), .o_Data_Ready(rdy_d[0]),
        .i_Ctrl_Valid(cv[0]), .i_Ctrl(cd[0]), .i_Ctrl_K(ck[0]), .o_Ctrl_Ready(rdy_c[0]),
        .o_S_en(s_en[0]), .o_Tx_Data(txd[0]), .o_Tx_K(txk[0]), .o_Word_Strobe(stb[0]),
        .o_State(st[0]), .o_Trained(trn[0]), .o_Data_Count(cnt[0]));

    serializer_tx_scheduler #(.DATA_WIDTH(8), .SLOT_CYCLES(S_B), .TRAIN_LEN(L_B),
                              .COMMA_PERIOD(P_B), .COMMA_CODE(8'hBC)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Link_En(link),
        .i_Data_Valid(dv[1]), .i_Data(dd[1]), .o_Data_Ready(rdy_d[1]),
        .i_Ctrl_Valid(cv[1]), .i_Ctrl(cd[1]), .i_Ctrl_K(ck[1]), .o_Ctrl_Ready(rdy_c[1]),
        .o_S_en(s_en[1]), .o_Tx_Data(txd[1]), .o_Tx_K(txk[1]), .o_Word_Strobe(stb[1]),
        .o_State(st[1]), .o_Trained(trn[1]), .o_Data_Count(cnt[1]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m = '{default: 0};
        m.dlast = 1;
        return m;
    endfunction

    function automatic int s_of(int i); return (i == 0) ? S_A : S_B; endfunction
    function automatic int l_of(int i); return (i == 0) ? L_A : L_B; endfunction
    function automatic int p_of(int i); return (i == 0) ? P_A : P_B; endfunction

    function automatic bit forced_slot(mdl_t m, int p);
        return (p != 0) && (m.run_slots == p - 1);
    endfunction

    // Who wins this slot: 0 none, 1 data, 2 control.
    function automatic int winner(mdl_t m, int p, bit lk, bit d_v, bit c_v);
        if (m.mode != 2 || m.phase != 0 || !lk || forced_slot(m, p)) return 0;
        if (c_v && (!d_v || m.dlast)) return 2;
        if (d_v) return 1;
        return 0;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int i, bit lk, bit d_v, bit c_v, bit c_k,
                                      logic [7:0] d_w, logic [7:0] c_w);
        mdl_t n = m;
        int   w;
        n.strobe = 0;
        if (m.mode == 0) begin
            if (lk) begin n.mode = 1; n.phase = 0; n.s_en = 1; end
            return n;
        end
        n.phase = (m.phase + 1) % s_of(i);
        if (m.phase != 0) return n;
        if (!lk) begin
            n.mode = 0; n.s_en = 0; n.data = 0; n.k = 0;
            n.sent = 0; n.run_slots = 0; n.phase = 0;
            return n;
        end
        n.strobe = 1;
        if (m.mode == 1) begin
            n.data = 8'hBC; n.k = 1; n.sent = m.sent + 1;
            if (n.sent == l_of(i)) n.mode = 2;
            return n;
        end
        if (forced_slot(m, p_of(i))) begin
            n.data = 8'hBC; n.k = 1; n.run_slots = 0;
            return n;
        end
        n.run_slots = m.run_slots + 1;
        w = winner(m, p_of(i), lk, d_v, c_v);
        if (w == 2) begin
            n.data = c_w; n.k = c_k; n.dlast = 0;
        end else if (w == 1) begin
            n.data = d_w; n.k = 0; n.dlast = 1; n.count = (m.count + 1) & 16'hFFFF;
        end else begin
            n.data = 8'hBC; n.k = 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_vec(mdl_t m);
        logic [1:0] md = m.mode[1:0];
        return {2'b0, md, (m.mode == 2), m.s_en, m.strobe, m.k, m.data, m.count[15:0]};
    endfunction

    function automatic logic [31:0] got_vec(int i);
        return {2'b0, st[i], trn[i], s_en[i], stb[i], txk[i], txd[i], cnt[i]};
    endfunction

    // Requesters hold their word until accepted; they may also withdraw.
    task automatic stim();
        for (int i = 0; i < 2; i++) begin
            if (fixed) begin
                dv[i] = 1; dd[i] = 8'h11; cv[i] = 1; cd[i] = 8'h22; ck[i] = 0;
            end else begin
                if (!dv[i] || acc_d[i]) begin
                    dv[i] = ($urandom_range(0, 99) < pd); dd[i] = 8'($urandom);
                end else if ($urandom_range(0, 15) == 0) dv[i] = 0;
                if (!cv[i] || acc_c[i]) begin
                    cv[i] = ($urandom_range(0, 99) < pc); cd[i] = 8'($urandom);
                    ck[i] = 1'($urandom);
                end else if ($urandom_range(0, 15) == 0) cv[i] = 0;
            end
            acc_d[i] = 0; acc_c[i] = 0;
        end
    endtask

    task automatic run_cycle();
        mdl_t nxt[2];
        int   w;
        #1;
        for (int i = 0; i < 2; i++) begin
            w = rst ? 0 : winner(mdl[i], p_of(i), link, dv[i], cv[i]);
            check(i == 0 ? "ready_a" : "ready_b", {30'b0, rdy_d[i], rdy_c[i]},
                  {30'b0, (w == 1), (w == 2)});
            acc_d[i] = (w == 1); acc_c[i] = (w == 2);
            nxt[i] = rst ? mdl_reset()
                         : mdl_step(mdl[i], i, link, dv[i], cv[i], ck[i], dd[i], cd[i]);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            mdl[i] = nxt[i];
            check(i == 0 ? "outs_a" : "outs_b", got_vec(i), exp_vec(mdl[i]));
        end
        @(negedge clk);
        stim();
    endtask

    task automatic apply_reset();
        rst = 1; #1;
        for (int i = 0; i < 2; i++) mdl[i] = mdl_reset();
        check("rst_now_a", got_vec(0), 32'h0);
        check("rst_now_b", got_vec(1), 32'h0);
    endtask

    logic [7:0] alt_exp [8] = '{8'h22, 8'h11, 8'h22, 8'hBC, 8'h11, 8'h22, 8'h11, 8'hBC};
    int train_strobes;

    initial begin
        for (int i = 0; i < 2; i++) begin
            dv[i] = 0; cv[i] = 0; ck[i] = 0; dd[i] = 0; cd[i] = 0;
            acc_d[i] = 0; acc_c[i] = 0; mdl[i] = mdl_reset();
        end
        @(negedge clk);
        apply_reset();
        run_cycle(); run_cycle();
        rst = 0;
        run_cycle();

        // Bring-up: 4 commas, RUN after the 5th edge
        link = 1; train_strobes = 0;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            if (stb[0] && txd[0] == 8'hBC && txk[0]) train_strobes++;
        end
        check("train_commas_a", 32'(train_strobes), 32'd4);
        check("trained_a", {30'b0, st[0], trn[0]}, {29'b0, 2'd2, 1'b1});

        // Both requesters saturated: ctrl first, alternate, forced comma each 4th slot
        fixed = 1; stim();
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            check("alt_word_a", {23'b0, txk[0], txd[0]},
                  {23'b0, (alt_exp[c] == 8'hBC), alt_exp[c]});
        end
        check("alt_count_a", 32'(cnt[0]), 32'd3);
        fixed = 0;

        // Randomised traffic with link flapping
        for (int c = 0; c < 3000; c++) begin
            pd = (c < 1500) ? 60 : 25;
            pc = (c < 1500) ? 40 : 20;
            if (link && $urandom_range(0, 299) == 0) link = 0;
            else if (!link && $urandom_range(0, 9) == 0) link = 1;
            run_cycle();
        end

        // Reset in the middle of training, then retrain from comma 1
        link = 0;
        for (int c = 0; c < 8; c++) run_cycle();
        link = 1;
        run_cycle(); run_cycle(); run_cycle();
        check("mid_train_a", {30'b0, st[0]}, 32'd1);
        apply_reset();
        run_cycle(); run_cycle();
        rst = 0;
        run_cycle();
        check("retrain_state_a", {30'b0, st[0]}, 32'd1);
        run_cycle();
        check("retrain_first_a", {22'b0, stb[0], txk[0], txd[0]}, {22'b0, 1'b1, 1'b1, 8'hBC});
        for (int c = 0; c < 200; c++) begin
            pd = 50; pc = 50;
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
